// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the sequential significand normalizer.
package fp_norm_pkg;

  localparam int unsigned W_DEF   = 8;
  localparam int unsigned SW_DEF  = 23;
  localparam int unsigned SHW_DEF = 5;

  localparam int unsigned EXP_MAX      = (1 << W_DEF) - 1;
  localparam int unsigned EXP_MIN_NORM = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  // Outcome of one normalization step; everything except STEP_SHIFT ends the op.
  typedef enum logic [2:0] {
    STEP_SHIFT  = 3'd0,
    STEP_ZERO   = 3'd1,
    STEP_RSHIFT = 3'd2,
    STEP_OVF    = 3'd3,
    STEP_NORM   = 3'd4,
    STEP_UNDER  = 3'd5
  } step_e;

endpackage

// File: rtl/mant_norm_seq_if.sv
// Request/result bundle between the FP datapath and the normalizer.
interface mant_norm_seq_if
  import fp_norm_pkg::*;
#(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned SW  = SW_DEF,
  parameter int unsigned SHW = SHW_DEF
);
  logic            start_i;
  logic [W-1:0]    exp_i;
  logic [SW+1:0]   mant_i;
  logic            ready_o;
  logic            done_o;
  logic [W-1:0]    exp_o;
  logic [SW+1:0]   mant_o;
  logic [SHW-1:0]  shift_o;
  logic            zero_o;
  logic            underflow_o;
  logic            overflow_o;

  modport master (
    output start_i, exp_i, mant_i,
    input  ready_o, done_o, exp_o, mant_o, shift_o, zero_o, underflow_o, overflow_o
  );

  modport slave (
    input  start_i, exp_i, mant_i,
    output ready_o, done_o, exp_o, mant_o, shift_o, zero_o, underflow_o, overflow_o
  );
endinterface

// File: rtl/norm_step.sv
// Combinational single-step normalization datapath; holds no state.
module norm_step
  import fp_norm_pkg::*;
#(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned SW  = SW_DEF,
  parameter int unsigned SHW = SHW_DEF
) (
  input  logic [SW+1:0]  mant_i,
  input  logic [W-1:0]   exp_i,
  input  logic [SHW-1:0] cnt_i,
  output logic [SW+1:0]  mant_c,
  output logic [W-1:0]   exp_c,
  output logic [SHW-1:0] cnt_c,
  output step_e          dec_c
);

  localparam logic [W-1:0] EXP_TOP = '1;

  logic [W-1:0] exp_inc;
  assign exp_inc = exp_i + W'(1);

  // Prioritized decision: zero, carry-out, normalized, exponent floor, left shift.
  always_comb begin
    mant_c = mant_i;
    exp_c  = exp_i;
    cnt_c  = cnt_i;
    dec_c  = STEP_NORM;
    if (mant_i == '0) begin
      dec_c  = STEP_ZERO;
      exp_c  = '0;
      cnt_c  = '0;
    end else if (mant_i[SW+1]) begin
      exp_c = exp_inc;
      cnt_c = '0;
      if (exp_inc == EXP_TOP) begin
        dec_c  = STEP_OVF;
        mant_c = '0;
      end else begin
        dec_c  = STEP_RSHIFT;
        mant_c = mant_i >> 1;
      end
    end else if (mant_i[SW]) begin
      dec_c = STEP_NORM;
    end else if (exp_i <= W'(EXP_MIN_NORM)) begin
      dec_c = STEP_UNDER;
    end else begin
      dec_c  = STEP_SHIFT;
      mant_c = mant_i << 1;
      exp_c  = exp_i - W'(1);
      cnt_c  = cnt_i + SHW'(1);
    end
  end

endmodule

// File: rtl/mant_norm_seq.sv
// Sequential post-add normalizer: one left shift per clock, or one right shift on carry-out.
module mant_norm_seq
  import fp_norm_pkg::*;
#(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned SW  = SW_DEF,
  parameter int unsigned SHW = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  mant_norm_seq_if.slave   bus
);

  state_e          state_q, state_d;
  logic [SW+1:0]   mant_q, mant_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [W-1:0]    exp_o_q, exp_o_d;
  logic [SW+1:0]   mant_o_q, mant_o_d;
  logic [SHW-1:0]  shift_q, shift_d;
  logic            zero_q, zero_d;
  logic            unf_q, unf_d;
  logic            ovf_q, ovf_d;

  logic [SW+1:0]   step_mant;
  logic [W-1:0]    step_exp;
  logic [SHW-1:0]  step_cnt;
  step_e           step_dec;

  norm_step #(.W(W), .SW(SW), .SHW(SHW)) u_step (
    .mant_i (mant_q),
    .exp_i  (exp_q),
    .cnt_i  (cnt_q),
    .mant_c (step_mant),
    .exp_c  (step_exp),
    .cnt_c  (step_cnt),
    .dec_c  (step_dec)
  );

  // State, working registers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      exp_o_q  <= '0;
      mant_o_q <= '0;
      shift_q  <= '0;
      zero_q   <= 1'b0;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      exp_o_q  <= exp_o_d;
      mant_o_q <= mant_o_d;
      shift_q  <= shift_d;
      zero_q   <= zero_d;
      unf_q    <= unf_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and next-output logic; results land in the output regs on the terminal step.
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    exp_o_d  = exp_o_q;
    mant_o_d = mant_o_q;
    shift_d  = shift_q;
    zero_d   = zero_q;
    unf_d    = unf_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_d = NORM;
          mant_d  = bus.mant_i;
          exp_d   = bus.exp_i;
          cnt_d   = '0;
          ready_d = 1'b0;
          shift_d = '0;
          zero_d  = 1'b0;
          unf_d   = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      NORM: begin
        if (step_dec == STEP_SHIFT) begin
          mant_d = step_mant;
          exp_d  = step_exp;
          cnt_d  = step_cnt;
        end else begin
          state_d  = DONE;
          ready_d  = 1'b1;
          done_d   = 1'b1;
          exp_o_d  = step_exp;
          mant_o_d = step_mant;
          shift_d  = step_cnt;
          zero_d   = (step_dec == STEP_ZERO);
          unf_d    = (step_dec == STEP_UNDER);
          ovf_d    = (step_dec == STEP_OVF);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.ready_o     = ready_q;
  assign bus.done_o      = done_q;
  assign bus.exp_o       = exp_o_q;
  assign bus.mant_o      = mant_o_q;
  assign bus.shift_o     = shift_q;
  assign bus.zero_o      = zero_q;
  assign bus.underflow_o = unf_q;
  assign bus.overflow_o  = ovf_q;

endmodule

// File: tb/tb_mant_norm_seq.sv
// Directed and randomized bench for mant_norm_seq against a closed-form reference model.
module tb_mant_norm_seq;

  localparam int unsigned W   = 8;
  localparam int unsigned SW  = 23;
  localparam int unsigned SHW = 5;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mant_norm_seq_if #(.W(W), .SW(SW), .SHW(SHW)) bus ();

  mant_norm_seq #(.W(W), .SW(SW), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count leading zeros below the hidden bit, clamp by how far the exponent may fall.
  task automatic model(input logic [7:0] e, input logic [24:0] m,
                       output logic [7:0] eo, output logic [24:0] mo, output int sh,
                       output bit z, output bit u, output bit o, output int lat);
    int msb, lz, allow, n;
    z = 0; u = 0; o = 0; sh = 0; lat = 1; eo = e; mo = m;
    if (m == 0) begin
      z = 1; eo = 0; mo = 0;
    end else if (m[24]) begin
      eo = 8'(e + 1);
      o  = (eo == 8'hFF);
      mo = o ? 25'd0 : (m >> 1);
    end else begin
      msb = 0;
      for (int b = 0; b <= 23; b++) if (m[b]) msb = b;
      lz    = 23 - msb;
      allow = (int'(e) > 1) ? int'(e) - 1 : 0;
      n     = (lz < allow) ? lz : allow;
      mo    = m << n;
      eo    = 8'(int'(e) - n);
      u     = (n < lz);
      sh    = n;
      lat   = n + 1;
    end
  endtask

  task automatic op_issue(input logic [7:0] e, input logic [24:0] m);
    bus.start_i = 1'b1;
    bus.exp_i   = e;
    bus.mant_i  = m;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  // Waits (bounded) for done_o and checks every result field plus latency.
  task automatic op_collect(input logic [7:0] e, input logic [24:0] m, input string tag);
    logic [7:0]  eo;
    logic [24:0] mo;
    int          sh, lat, k;
    bit          z, u, o, seen;
    model(e, m, eo, mo, sh, z, u, o, lat);
    seen = 0;
    k    = 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      if (bus.done_o) begin
        seen = 1;
        k    = c;
        break;
      end
    end
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, ".latency"}, 32'(k), 32'(lat));
      chk({tag, ".exp"},     32'(bus.exp_o), 32'(eo));
      chk({tag, ".mant"},    32'(bus.mant_o), 32'(mo));
      chk({tag, ".shift"},   32'(bus.shift_o), 32'(sh));
      chk({tag, ".flags"},   {29'd0, bus.zero_o, bus.underflow_o, bus.overflow_o},
                             {29'd0, z, u, o});
      chk({tag, ".ready"},   32'(bus.ready_o), 32'd1);
    end
  endtask

  initial begin
    logic [7:0]  re;
    logic [24:0] rm;
    n_cmp = 0;
    n_err = 0;
    bus.start_i = 1'b0;
    bus.exp_i   = '0;
    bus.mant_i  = '0;
    rst_n = 1'b0;
    #12;
    chk("rst.ready", 32'(bus.ready_o), 32'd1);
    chk("rst.done",  32'(bus.done_o), 32'd0);
    chk("rst.outs",  32'(bus.exp_o) | 32'(bus.mant_o) | 32'(bus.shift_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    op_issue(8'h80, 25'h0800000); op_collect(8'h80, 25'h0800000, "T1");
    @(posedge clk); #1;
    chk("T1.done_pulse", 32'(bus.done_o), 32'd0);
    chk("T1.hold_exp",   32'(bus.exp_o), 32'h80);

    op_issue(8'h80, 25'h0000100); op_collect(8'h80, 25'h0000100, "T2");
    op_issue(8'hFE, 25'h1000000); op_collect(8'hFE, 25'h1000000, "T3");
    op_issue(8'h03, 25'h0000001); op_collect(8'h03, 25'h0000001, "T4");
    op_issue(8'h00, 25'h0400000); op_collect(8'h00, 25'h0400000, "exp0");
    op_issue(8'h40, 25'h1FFFFFF); op_collect(8'h40, 25'h1FFFFFF, "rshift");

    // Back-to-back: start held in the DONE cycle, no IDLE in between.
    op_issue(8'h55, 25'h0000000); op_collect(8'h55, 25'h0000000, "T5");
    op_issue(8'h80, 25'h0000100);
    chk("T5.b2b_accept", 32'(bus.ready_o), 32'd0);
    op_collect(8'h80, 25'h0000100, "T5b");

    // Async reset five shifts into T2.
    op_issue(8'h80, 25'h0000100);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("T6.ready", 32'(bus.ready_o), 32'd1);
    chk("T6.outs",  32'(bus.exp_o) | 32'(bus.mant_o) | 32'(bus.shift_o), 32'd0);
    chk("T6.flags", {29'd0, bus.zero_o, bus.underflow_o, bus.overflow_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    begin
      bit any_done;
      any_done = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (bus.done_o) any_done = 1;
      end
      chk("T6.no_done", 32'(any_done), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      re = 8'($urandom);
      if (i % 5 == 0) re = 8'($urandom_range(0, 4));
      rm = 25'($urandom) >> $urandom_range(0, 25);
      op_issue(re, rm);
      op_collect(re, rm, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
